// File: rtl/spi_tft_pkg.sv
// Shared definitions for the TFT SPI path: FSM state encoding, SPI mode
// and the D/C line encodings used by the byte transmitter, the screen-init
// sequencer and the pixel writer.
package spi_tft_pkg;

    // One-hot state encoding of the byte transmitter FSM.
    typedef enum logic [4:0] {
        S_IDLE  = 5'b00001,
        S_LOAD  = 5'b00010,
        S_SHIFT = 5'b00100,
        S_ACK   = 5'b01000,
        S_HOLD  = 5'b10000
    } state_t;

    // SPI mode 0: CPOL=0 (SCLK idles low), CPHA=0 (data valid on rising edge,
    // changed on falling edge; first bit presented before the first edge).
    localparam logic [1:0] SPI_MODE   = 2'd0;
    localparam logic       SPI_CPOL   = SPI_MODE[1];
    localparam logic       SCLK_IDLE  = SPI_CPOL;

    // Panel D/C line encodings.
    localparam logic DC_CMD  = 1'b0;
    localparam logic DC_DATA = 1'b1;

    localparam int unsigned BITS_PER_BYTE = 8;

endpackage

// File: rtl/spi_tft_sclk_gen.sv
// SCLK timing generator. While enabled it divides sys_clk by CLK_DIV and
// alternates between rising and falling edge ticks; the first tick after
// enable is always a rising edge. Disabled means counter and phase cleared.
module spi_tft_sclk_gen #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic enable,
    output logic rise_tick,
    output logic fall_tick
);

    localparam logic [7:0] DIV_MAX = 8'(CLK_DIV - 1);

    logic [7:0] div_cnt;
    logic       phase;      // current SCLK level as seen by the generator
    logic       wrap;

    assign wrap      = enable && (div_cnt == DIV_MAX);
    assign rise_tick = wrap && !phase;
    assign fall_tick = wrap && phase;

    // Half-period counter and SCLK phase tracking.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            div_cnt <= 8'd0;
            phase   <= 1'b0;
        end else if (!enable) begin
            div_cnt <= 8'd0;
            phase   <= 1'b0;
        end else if (wrap) begin
            div_cnt <= 8'd0;
            phase   <= ~phase;
        end else begin
            div_cnt <= div_cnt + 8'd1;
        end
    end

endmodule

// File: rtl/spi_tft_byte_tx.sv
// Byte-level SPI mode-0 transmitter for the TFT panel. Takes one byte plus
// its D/C flag per request/ack handshake and keeps CS low across
// back-to-back bytes until upstream asks for end-of-transfer.
//
// Handshake: upstream raises tx_req_i with tx_data_i/tx_dc_i valid and keeps
// all three stable until the byte is accepted (the edge entering S_LOAD).
// tx_ack_o pulses for one cycle once the byte has been fully shifted out;
// upstream may then either keep tx_req_i high with the next byte (the
// request is looked at again in S_HOLD) or drop it. tx_end_i is only
// honoured in S_HOLD when no new request is pending.
module spi_tft_byte_tx
    import spi_tft_pkg::*;
#(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       tx_req_i,
    input  logic [7:0] tx_data_i,
    input  logic       tx_dc_i,
    input  logic       tx_end_i,
    output logic       tx_ack_o,
    output logic       tx_busy_o,
    output logic       spi_sclk_o,
    output logic       spi_mosi_o,
    output logic       spi_cs_o,
    output logic       spi_dc_o
);

    state_t     state;
    state_t     state_nxt;

    // Bit 7 goes straight to MOSI on load; the remaining 7 bits wait here.
    logic [6:0] shift_reg;
    logic [2:0] bit_cnt;    // rising edges seen; wraps to 0 after the 8th
    logic       shift_en;
    logic       rise_tick;
    logic       fall_tick;
    logic       last_fall;
    logic       load_en;
    logic       release_en;

    assign shift_en   = (state == S_SHIFT);
    // The first fall always follows a rise, so bit_cnt==0 here means 8 rises.
    assign last_fall  = fall_tick && (bit_cnt == 3'd0);
    assign load_en    = (state_nxt == S_LOAD);
    assign release_en = (state == S_HOLD) && (state_nxt == S_IDLE);

    assign tx_ack_o   = (state == S_ACK);
    assign tx_busy_o  = (state != S_IDLE);

    spi_tft_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .enable    (shift_en),
        .rise_tick (rise_tick),
        .fall_tick (fall_tick)
    );

    // State register.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; a pending request in S_HOLD wins over end-of-transfer.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (tx_req_i) state_nxt = S_LOAD;
            S_LOAD:  state_nxt = S_SHIFT;
            S_SHIFT: if (last_fall) state_nxt = S_ACK;
            S_ACK:   state_nxt = S_HOLD;
            S_HOLD: begin
                if (tx_req_i) begin
                    state_nxt = S_LOAD;
                end else if (tx_end_i) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Shift register, bit counter and registered SPI pins.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            shift_reg  <= 7'd0;
            bit_cnt    <= 3'd0;
            spi_sclk_o <= SCLK_IDLE;
            spi_mosi_o <= 1'b0;
            spi_cs_o   <= 1'b1;
            spi_dc_o   <= DC_CMD;
        end else if (load_en) begin
            // Accept the byte: pins show CS low, D/C and bit 7 during S_LOAD.
            shift_reg  <= tx_data_i[6:0];
            bit_cnt    <= 3'd0;
            spi_mosi_o <= tx_data_i[7];
            spi_cs_o   <= 1'b0;
            spi_dc_o   <= tx_dc_i;
        end else if (release_en) begin
            spi_mosi_o <= 1'b0;
            spi_cs_o   <= 1'b1;
            spi_dc_o   <= DC_CMD;
        end else if (shift_en) begin
            if (rise_tick) begin
                spi_sclk_o <= ~SCLK_IDLE;
                bit_cnt    <= bit_cnt + 3'd1;
            end
            if (fall_tick) begin
                spi_sclk_o <= SCLK_IDLE;
                // After the final falling edge MOSI keeps the last bit.
                if (!last_fall) begin
                    spi_mosi_o <= shift_reg[6];
                    shift_reg  <= {shift_reg[5:0], 1'b0};
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_tft_byte_tx.sv
// Testbench for spi_tft_byte_tx: one instance with CLK_DIV=2 and one with
// CLK_DIV=1. An SPI monitor rebuilds bytes from the pins and checks them
// against an expected queue filled by the driver tasks.
module tb_spi_tft_byte_tx;
    import spi_tft_pkg::*;

    localparam int NI   = 2;
    localparam int DIV0 = 2;
    localparam int DIV1 = 1;

    function automatic int div_of(input int i);
        return (i == 0) ? DIV0 : DIV1;
    endfunction

    // ---------------- clock / reset ----------------
    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b0;
    int   cyc       = 0;

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    // ---------------- DUT signals ----------------
    logic       tx_req  [NI];
    logic [7:0] tx_data [NI];
    logic       tx_dc   [NI];
    logic       tx_end  [NI];
    logic       tx_ack  [NI];
    logic       tx_busy [NI];
    logic       sclk    [NI];
    logic       mosi    [NI];
    logic       cs      [NI];
    logic       dc      [NI];

    spi_tft_byte_tx #(.CLK_DIV(DIV0)) dut_div2 (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .tx_req_i   (tx_req[0]),
        .tx_data_i  (tx_data[0]),
        .tx_dc_i    (tx_dc[0]),
        .tx_end_i   (tx_end[0]),
        .tx_ack_o   (tx_ack[0]),
        .tx_busy_o  (tx_busy[0]),
        .spi_sclk_o (sclk[0]),
        .spi_mosi_o (mosi[0]),
        .spi_cs_o   (cs[0]),
        .spi_dc_o   (dc[0])
    );

    spi_tft_byte_tx #(.CLK_DIV(DIV1)) dut_div1 (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .tx_req_i   (tx_req[1]),
        .tx_data_i  (tx_data[1]),
        .tx_dc_i    (tx_dc[1]),
        .tx_end_i   (tx_end[1]),
        .tx_ack_o   (tx_ack[1]),
        .tx_busy_o  (tx_busy[1]),
        .spi_sclk_o (sclk[1]),
        .spi_mosi_o (mosi[1]),
        .spi_cs_o   (cs[1]),
        .spi_dc_o   (dc[1])
    );

    // ---------------- scoreboard state ----------------
    logic [9:0] exp_q[$];          // {instance, dc, byte}
    int n_checks = 0;
    int n_fail   = 0;
    int rises        [NI];
    int acks         [NI];
    int cs_rises     [NI];
    int exp_rises    [NI];
    int exp_acks     [NI];
    int exp_cs_rises [NI];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- SPI monitor ----------------
    initial begin
        logic       prev_sclk [NI];
        logic       prev_cs   [NI];
        logic       prev_mosi [NI];
        logic       prev_ack  [NI];
        int         mosi_chg  [NI];
        int         nbits     [NI];
        logic [7:0] sh        [NI];
        logic       mdc       [NI];
        logic [9:0] exp_e;
        for (int i = 0; i < NI; i++) begin
            prev_sclk[i] = 1'b0; prev_cs[i] = 1'b1; prev_mosi[i] = 1'b0;
            prev_ack[i] = 1'b0; mosi_chg[i] = 0; nbits[i] = 0;
            sh[i] = 8'd0; mdc[i] = 1'b0;
            rises[i] = 0; acks[i] = 0; cs_rises[i] = 0;
        end
        forever begin
            @(negedge sys_clk);
            for (int i = 0; i < NI; i++) begin
                if (cs[i] && !prev_cs[i]) cs_rises[i]++;
                prev_cs[i] = cs[i];
                if (mosi[i] !== prev_mosi[i]) begin
                    mosi_chg[i]  = cyc;
                    prev_mosi[i] = mosi[i];
                end
                if (!sys_rst_n) begin
                    nbits[i]     = 0;
                    prev_sclk[i] = 1'b0;
                    prev_ack[i]  = 1'b0;
                end else begin
                    if (tx_ack[i]) begin
                        acks[i]++;
                        check("ack_one_cycle", prev_ack[i], 1'b0);
                    end
                    prev_ack[i] = tx_ack[i];
                    if (sclk[i] && !prev_sclk[i]) begin
                        rises[i]++;
                        check("cs_low_at_rise", cs[i], 1'b0);
                        check("mosi_setup", (cyc - mosi_chg[i]) >= div_of(i), 1'b1);
                        if (nbits[i] == 0) mdc[i] = dc[i];
                        else check("dc_stable", dc[i], mdc[i]);
                        sh[i] = {sh[i][6:0], mosi[i]};
                        nbits[i]++;
                        if (nbits[i] == 8) begin
                            nbits[i] = 0;
                            check("exp_q_nonempty", exp_q.size() > 0, 1'b1);
                            if (exp_q.size() > 0) begin
                                exp_e = exp_q.pop_front();
                                check("spi_byte", {i[0], mdc[i], sh[i]}, exp_e);
                            end
                        end
                    end
                    prev_sclk[i] = sclk[i];
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called on a negedge; returns on the negedge where tx_ack_o is seen.
    task automatic send_byte(input int inst, input logic [7:0] data, input logic dcf,
                             input bit keep, input bit chk_lat, input bit end_mid);
        int c0;
        bit got;
        tx_data[inst] = data;
        tx_dc[inst]   = dcf;
        tx_req[inst]  = 1'b1;
        exp_q.push_back({inst[0], dcf, data});
        exp_acks[inst]++;
        exp_rises[inst] += 8;
        c0  = cyc;
        got = 1'b0;
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge sys_clk);
            if (k == 4) begin
                tx_data[inst] = 8'($urandom);
                tx_dc[inst]   = 1'($urandom);
            end
            if (end_mid && k == 12) tx_end[inst] = 1'b1;
            if (tx_ack[inst]) got = 1'b1;
        end
        check("ack_seen", got, 1'b1);
        if (chk_lat) check("ack_latency", cyc - c0, 2 + 16 * div_of(inst));
        if (!keep) tx_req[inst] = 1'b0;
    endtask

    // Called on the ack negedge with the request dropped.
    task automatic end_xfer(input int inst);
        tx_end[inst] = 1'b1;
        @(negedge sys_clk);
        check("cs_low_in_hold", cs[inst], 1'b0);
        check("busy_in_hold", tx_busy[inst], 1'b1);
        check("sclk_low_in_hold", sclk[inst], SCLK_IDLE);
        @(negedge sys_clk);
        check("cs_released", cs[inst], 1'b1);
        check("idle_after_end", tx_busy[inst], 1'b0);
        check("dc_idle", dc[inst], DC_CMD);
        tx_end[inst] = 1'b0;
        exp_cs_rises[inst]++;
    endtask

    task automatic hold_wait(input int inst, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge sys_clk);
            check("hold_cs_low", cs[inst], 1'b0);
            check("hold_busy", tx_busy[inst], 1'b1);
        end
    endtask

    task automatic reset_mid_byte();
        int   seen = 0;
        logic p    = 1'b0;
        bit   done = 1'b0;
        tx_data[0] = 8'hFF;
        tx_dc[0]   = DC_DATA;
        tx_req[0]  = 1'b1;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge sys_clk);
            if (sclk[0] && !p) seen++;
            p = sclk[0];
            if (seen == 4) done = 1'b1;
        end
        check("reached_4_rises", seen, 4);
        exp_rises[0] += 4;
        exp_cs_rises[0]++;
        #2;
        sys_rst_n = 1'b0;
        tx_req[0] = 1'b0;
        #1;
        check("rst_cs", cs[0], 1'b1);
        check("rst_sclk", sclk[0], 1'b0);
        check("rst_mosi", mosi[0], 1'b0);
        check("rst_ack", tx_ack[0], 1'b0);
        check("rst_busy", tx_busy[0], 1'b0);
        @(negedge sys_clk);
        #2;
        sys_rst_n = 1'b1;
    endtask

    // Screen-init sequence as {dc, byte}.
    logic [8:0] init_seq [19] = '{
        {DC_CMD, 8'h01}, {DC_CMD, 8'h11},
        {DC_CMD, 8'h3A}, {DC_DATA, 8'h55},
        {DC_CMD, 8'h36}, {DC_DATA, 8'h78},
        {DC_CMD, 8'h2A}, {DC_DATA, 8'h00}, {DC_DATA, 8'h00}, {DC_DATA, 8'h01}, {DC_DATA, 8'h3F},
        {DC_CMD, 8'h2B}, {DC_DATA, 8'h00}, {DC_DATA, 8'h00}, {DC_DATA, 8'h00}, {DC_DATA, 8'hEF},
        {DC_CMD, 8'h21}, {DC_CMD, 8'h13}, {DC_CMD, 8'h29}
    };

    // ---------------- main stimulus ----------------
    initial begin
        int  a0;
        bit  keep;
        int  act;
        for (int i = 0; i < NI; i++) begin
            tx_req[i] = 1'b0; tx_data[i] = 8'd0; tx_dc[i] = 1'b0; tx_end[i] = 1'b0;
            exp_rises[i] = 0; exp_acks[i] = 0; exp_cs_rises[i] = 0;
        end
        sys_rst_n = 1'b0;
        repeat (3) @(negedge sys_clk);
        for (int i = 0; i < NI; i++) begin
            check("reset_cs", cs[i], 1'b1);
            check("reset_sclk", sclk[i], 1'b0);
            check("reset_mosi", mosi[i], 1'b0);
            check("reset_dc", dc[i], 1'b0);
            check("reset_ack", tx_ack[i], 1'b0);
            check("reset_busy", tx_busy[i], 1'b0);
        end
        sys_rst_n = 1'b1;
        @(negedge sys_clk);

        // Single byte 0x3A, command.
        send_byte(0, 8'h3A, DC_CMD, 1'b0, 1'b1, 1'b0);
        end_xfer(0);

        // Back-to-back 0x2A (cmd) then 0x00 (data) in one CS frame.
        @(negedge sys_clk);
        send_byte(0, 8'h2A, DC_CMD, 1'b1, 1'b1, 1'b0);
        send_byte(0, 8'h00, DC_DATA, 1'b0, 1'b0, 1'b0);
        end_xfer(0);

        // End raised mid-shift is ignored; req+end together in S_HOLD starts a byte.
        @(negedge sys_clk);
        send_byte(0, 8'hC5, DC_DATA, 1'b1, 1'b1, 1'b1);
        send_byte(0, 8'h5C, DC_CMD, 1'b0, 1'b0, 1'b0);
        end_xfer(0);

        // Reset in the middle of 0xFF, then a full byte.
        @(negedge sys_clk);
        reset_mid_byte();
        @(negedge sys_clk);
        send_byte(0, 8'hFF, DC_DATA, 1'b0, 1'b1, 1'b0);
        end_xfer(0);

        // CLK_DIV=1 boundary.
        @(negedge sys_clk);
        send_byte(1, 8'h80, DC_DATA, 1'b0, 1'b1, 1'b0);
        end_xfer(1);

        // Screen-init sequence: each command plus its parameters in one frame.
        @(negedge sys_clk);
        #1;
        a0 = acks[0];
        @(negedge sys_clk);
        for (int i = 0; i < 19; i++) begin
            keep = (i < 18) && (init_seq[i + 1][8] == DC_DATA);
            send_byte(0, init_seq[i][7:0], init_seq[i][8], keep, 1'b0, 1'b0);
            if (!keep) begin
                end_xfer(0);
                repeat ($urandom_range(0, 3)) @(negedge sys_clk);
            end
        end
        @(negedge sys_clk);
        #1;
        check("init_ack_count", acks[0] - a0, 19);
        @(negedge sys_clk);

        // Randomized bytes and inter-byte behaviour on the CLK_DIV=2 instance.
        for (int n = 0; n < 24; n++) begin
            act = $urandom_range(0, 2);
            send_byte(0, 8'($urandom), 1'($urandom), (act == 0) && (n != 23), 1'b0, 1'b0);
            if (act == 2 || n == 23) begin
                end_xfer(0);
                repeat ($urandom_range(0, 2)) @(negedge sys_clk);
            end else if (act == 1) begin
                hold_wait(0, $urandom_range(1, 3));
            end
        end

        // Randomized single bytes on the CLK_DIV=1 instance.
        for (int n = 0; n < 6; n++) begin
            @(negedge sys_clk);
            send_byte(1, 8'($urandom), 1'($urandom), 1'b0, 1'b1, 1'b0);
            end_xfer(1);
        end

        repeat (3) @(negedge sys_clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            check("ack_count", acks[i], exp_acks[i]);
            check("rise_count", rises[i], exp_rises[i]);
            check("cs_rise_count", cs_rises[i], exp_cs_rises[i]);
        end
        check("exp_q_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time bound.
    initial begin
        #1_000_000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
